// File: rtl/usb_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | usb_packer: frames AD FIFO words into USB packets (sync/seq/len/payload/sum) |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module usb_packer #(
  parameter logic [15:0] SYNC_WORD   = 16'hA55A,
  parameter int          PAYLOAD_MAX = 252
) (
  input  logic        i_clk_sys,
  input  logic        i_rst_n,
  input  logic        i_st,
  input  logic [15:0] i_recv_count,
  input  logic [15:0] i_ad_data,
  input  logic        i_ad_empty,
  output logic        o_ad_rd,
  input  logic        i_usb_afull,
  output logic        o_usb_wr,
  output logic [15:0] o_usb_data,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam logic [15:0] C_PAY_MAX = 16'(PAYLOAD_MAX);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_SEQ  = 3'd2,
    S_LEN  = 3'd3,
    S_PAY  = 3'd4,
    S_SUM  = 3'd5
  } state_t;

  state_t      r_state;
  logic [15:0] r_remaining;
  logic [15:0] r_seq;
  logic [15:0] r_len;
  logic [15:0] r_pay_cnt;
  logic [15:0] r_sum;

  logic        w_pay_issue;
  logic [15:0] w_rem_next;
  logic [15:0] w_len_start;
  logic [15:0] w_len_next;

  assign w_pay_issue = (r_state == S_PAY) && !i_ad_empty && !i_usb_afull;
  assign w_rem_next  = r_remaining - r_len;
  assign w_len_start = (i_recv_count < C_PAY_MAX) ? i_recv_count : C_PAY_MAX;
  assign w_len_next  = (w_rem_next < C_PAY_MAX) ? w_rem_next : C_PAY_MAX;

  assign o_ad_rd = w_pay_issue;
  assign o_busy  = (r_state != S_IDLE);

  always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_remaining  <= 16'h0000;
      r_seq        <= 16'h0000;
      r_len        <= 16'h0000;
      r_pay_cnt    <= 16'h0000;
      r_sum        <= 16'h0000;
      o_usb_wr     <= 1'b0;
      o_usb_data   <= 16'h0000;
      o_frame_done <= 1'b0;
    end else begin
      o_usb_wr     <= 1'b0;
      o_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_st) begin
            r_remaining <= i_recv_count;
            r_seq       <= 16'h0000;
            if (i_recv_count == 16'h0000) begin
              o_frame_done <= 1'b1;
            end else begin
              r_state   <= S_HDR;
              r_len     <= w_len_start;
              r_sum     <= 16'h0000;
              r_pay_cnt <= 16'h0000;
            end
          end
        end
        S_HDR: begin
          if (!i_usb_afull) begin
            o_usb_wr   <= 1'b1;
            o_usb_data <= SYNC_WORD;
            r_state    <= S_SEQ;
          end
        end
        S_SEQ: begin
          if (!i_usb_afull) begin
            o_usb_wr   <= 1'b1;
            o_usb_data <= r_seq;
            r_state    <= S_LEN;
          end
        end
        S_LEN: begin
          if (!i_usb_afull) begin
            o_usb_wr   <= 1'b1;
            o_usb_data <= r_len;
            r_sum      <= r_sum + r_len;
            r_state    <= S_PAY;
          end
        end
        S_PAY: begin
          if (w_pay_issue) begin
            o_usb_wr   <= 1'b1;
            o_usb_data <= i_ad_data;
            r_sum      <= r_sum + i_ad_data;
            if (r_pay_cnt == r_len - 16'd1) begin
              r_pay_cnt <= 16'h0000;
              r_state   <= S_SUM;
            end else begin
              r_pay_cnt <= r_pay_cnt + 16'd1;
            end
          end
        end
        S_SUM: begin
          if (!i_usb_afull) begin
            o_usb_wr    <= 1'b1;
            o_usb_data  <= r_sum;
            r_remaining <= w_rem_next;
            r_seq       <= r_seq + 16'd1;
            // Done pulse lines up with the checksum strobe on the USB side.
            if (w_rem_next == 16'h0000) begin
              r_state      <= S_IDLE;
              o_frame_done <= 1'b1;
            end else begin
              r_state   <= S_HDR;
              r_len     <= w_len_next;
              r_sum     <= 16'h0000;
              r_pay_cnt <= 16'h0000;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_usb_packer: random/directed stimulus against a packet-level reference     |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_usb_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st;
  logic [15:0] recv_count;
  logic [15:0] ad_data = 16'h0000;
  logic        ad_empty = 1'b1;
  logic        ad_rd;
  logic        usb_afull = 1'b0;
  logic        usb_wr;
  logic [15:0] usb_data;
  logic        busy;
  logic        frame_done;

  int n_asserts = 0;
  int n_fails   = 0;
  int done_cnt  = 0;
  int done_target = 0;
  int wr_cnt    = 0;
  int afull_pct = 0;
  int cyc       = 0;
  int empty_until = 0;
  int rd_idx    = 0;
  int exp_rd    = 0;
  bit pop_pend  = 1'b0;
  bit afull_prev = 1'b0;

  logic [15:0] fifo_q[$];
  logic [15:0] exp_q[$];

  usb_packer dut (
    .i_clk_sys    (clk),
    .i_rst_n      (rst_n),
    .i_st         (st),
    .i_recv_count (recv_count),
    .i_ad_data    (ad_data),
    .i_ad_empty   (ad_empty),
    .o_ad_rd      (ad_rd),
    .i_usb_afull  (usb_afull),
    .o_usb_wr     (usb_wr),
    .o_usb_data   (usb_data),
    .o_busy       (busy),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_asserts++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Show-ahead FIFO and backpressure source, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (!rst_n) rd_idx = fifo_q.size();
    else if (pop_pend) rd_idx++;
    usb_afull = ($urandom_range(0, 99) < afull_pct);
    ad_empty  = (rd_idx >= fifo_q.size()) || (cyc < empty_until);
    ad_data   = (rd_idx < fifo_q.size()) ? fifo_q[rd_idx] : 16'h0000;
  end

  // USB-side scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_rd = exp_q.size();
    end else begin
      if (usb_wr) begin
        wr_cnt++;
        if (exp_rd < exp_q.size()) begin
          chk("usb_data", usb_data, exp_q[exp_rd]);
          exp_rd++;
        end else begin
          chk("usb_wr_unexpected", 32'(usb_wr), 0);
        end
        chk("wr_after_afull", 32'(afull_prev), 0);
      end
      if (ad_rd) chk("ad_rd_blocked", 32'(ad_empty | usb_afull), 0);
      if (frame_done) begin
        done_cnt++;
        chk("done_early", exp_q.size() - exp_rd, 0);
      end
    end
    pop_pend   = ad_rd;
    afull_prev = usb_afull;
  end

  // Reference: split the frame into packets of at most 252 words and list every USB word.
  task automatic prepare(input int count, input int mode);
    logic [15:0] pay[$];
    logic [15:0] w, seq, sum;
    int rem, len, idx;
    for (int i = 0; i < count; i++) begin
      w = (mode == 0) ? 16'($urandom) : (mode == 1) ? 16'(i + 1) : 16'hFFFF;
      pay.push_back(w);
      fifo_q.push_back(w);
    end
    rem = count; seq = 16'h0000; idx = 0;
    while (rem > 0) begin
      len = (rem < 252) ? rem : 252;
      exp_q.push_back(16'hA55A);
      exp_q.push_back(seq);
      exp_q.push_back(16'(len));
      sum = 16'(len);
      for (int k = 0; k < len; k++) begin
        sum = sum + pay[idx];
        exp_q.push_back(pay[idx]);
        idx++;
      end
      exp_q.push_back(sum);
      rem = rem - len;
      seq = seq + 16'd1;
    end
  endtask

  task automatic pulse(input logic [15:0] cnt);
    @(posedge clk); #1;
    st = 1'b1; recv_count = cnt;
    @(posedge clk); #1;
    st = 1'b0; recv_count = 16'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    done_target++;
    while (done_cnt < done_target && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    chk("done_timeout", 32'(done_cnt >= done_target), 1);
    repeat (3) @(negedge clk);
    #1;
    chk("done_count", done_cnt, done_target);
    chk("words_left", exp_q.size() - exp_rd, 0);
    chk("fifo_left", fifo_q.size() - rd_idx, 0);
  endtask

  task automatic run(input int count, input int mode, input int pct);
    afull_pct = pct;
    prepare(count, mode);
    pulse(16'(count));
    wait_done(20000);
    afull_pct = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0;
    rst_n = 1'b0; st = 1'b0; recv_count = 16'h0000;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_usb_wr", 32'(usb_wr), 0);
    chk("rst_usb_data", usb_data, 0);
    chk("rst_ad_rd", 32'(ad_rd), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(frame_done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Short frame, cycle-exact: words on cycles 2..9, done on cycle 9.
    prepare(4, 1);
    @(posedge clk); #1;
    st = 1'b1; recv_count = 16'd4;
    @(negedge clk); #1;
    chk("short_wr_c0", 32'(usb_wr), 0);
    @(posedge clk); #1;
    st = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk); #1;
      chk("short_wr", 32'(usb_wr), 32'(c >= 2 && c <= 9));
      chk("short_done", 32'(frame_done), 32'(c == 9));
      if (c == 1) chk("short_busy", 32'(busy), 1);
      if (c == 11) chk("short_idle", 32'(busy), 0);
    end
    done_target++;
    chk("short_done_count", done_cnt, done_target);

    run(300, 0, 0);
    run(300, 0, 30);
    run(8, 0, 50);
    run(252, 0, 20);
    run(253, 0, 0);
    run(4, 2, 0);

    // FIFO runs dry for 10 cycles mid-payload.
    prepare(40, 0);
    pulse(16'd40);
    repeat (6) @(negedge clk);
    empty_until = cyc + 10;
    wait_done(2000);

    // Header words flow while the FIFO is empty; payload waits.
    prepare(10, 0);
    empty_until = cyc + 30;
    w0 = wr_cnt;
    pulse(16'd10);
    repeat (4) @(negedge clk);
    #1;
    chk("hdr_while_empty", wr_cnt - w0, 3);
    repeat (5) @(negedge clk);
    #1;
    chk("pay_stalled", wr_cnt - w0, 3);
    wait_done(2000);

    // Zero count: done one cycle after start, no writes.
    w0 = wr_cnt;
    @(posedge clk); #1;
    st = 1'b1; recv_count = 16'd0;
    @(negedge clk); #1;
    chk("zero_done_c0", 32'(frame_done), 0);
    @(posedge clk); #1;
    st = 1'b0;
    @(negedge clk); #1;
    chk("zero_done_c1", 32'(frame_done), 1);
    chk("zero_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    #1;
    done_target++;
    chk("zero_done_count", done_cnt, done_target);
    chk("zero_no_wr", wr_cnt - w0, 0);

    // Start while busy is ignored.
    prepare(30, 0);
    pulse(16'd30);
    repeat (8) @(negedge clk);
    pulse(16'd5);
    wait_done(2000);

    // Reset mid-payload, then a clean frame starting at seq 0.
    prepare(50, 0);
    pulse(16'd50);
    repeat (10) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_usb_wr", 32'(usb_wr), 0);
    chk("mid_rst_usb_data", usb_data, 0);
    chk("mid_rst_ad_rd", 32'(ad_rd), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_done", 32'(frame_done), 0);
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    run(6, 0, 0);
    run(260, 0, 25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
